// File: rtl/fifo_row_loader_pkg.sv
// Shared loader types and sizing defaults.
// Array dimension sets the default row length.
package fifo_row_loader_pkg;

  localparam int LDR_DATA_WIDTH = 8;
  localparam int ARRAY_DIM      = 4;
  localparam int LDR_ROW_LEN    = ARRAY_DIM;
  localparam int LDR_ROWS_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRESENT,
    ST_FINISH
  } ldr_state_t;

endpackage

// File: rtl/fifo_row_loader.sv
// Drains the byte FIFO into ROW_LEN-element rows,
// presents each row on valid/ready, pulses done after num_rows.
// Ports: clk/rst (sync, active-high); start/num_rows command;
//   busy/done status; fifo_empty/fifo_re/fifo_r_data FIFO side;
//   row_valid/row_ready/row_data row output.
module fifo_row_loader
  import fifo_row_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LDR_DATA_WIDTH,
  parameter int ROW_LEN    = LDR_ROW_LEN,
  parameter int ROWS_W     = LDR_ROWS_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS_W-1:0]             num_rows,
  output logic                          busy,
  output logic                          done,
  input  logic                          fifo_empty,
  output logic                          fifo_re,
  input  logic [DATA_WIDTH-1:0]         fifo_r_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [ROW_LEN*DATA_WIDTH-1:0] row_data
);

  localparam int CW = $clog2(ROW_LEN + 1);
  localparam logic [CW-1:0] ROW_LEN_C = CW'(ROW_LEN);
  localparam logic [CW-1:0] LAST_C    = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  ldr_state_t state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] captured_q, captured_d;
  logic [ROWS_W-1:0] rows_done_q, rows_done_d;
  logic [ROWS_W-1:0] num_rows_q, num_rows_d;
  logic pending_q, pending_d;
  logic [ROW_LEN*DATA_WIDTH-1:0] row_q, row_d;
  logic last_row;

  // One extra bit so the compare holds up to 2^ROWS_W-1 rows.
  assign last_row = ({1'b0, rows_done_q} + (ROWS_W+1)'(1))
                    == {1'b0, num_rows_q};

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    captured_d  = captured_q;
    rows_done_d = rows_done_q;
    num_rows_d  = num_rows_q;
    row_d       = row_q;
    pending_d   = 1'b0;
    fifo_re     = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FINISH);
    row_valid   = (state_q == ST_PRESENT);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_rows_d  = num_rows;
          rows_done_d = '0;
          issued_d    = '0;
          captured_d  = '0;
          state_d     = (num_rows == '0) ? ST_FINISH : ST_FILL;
        end
      end
      ST_FILL: begin
        fifo_re   = !fifo_empty && (issued_q < ROW_LEN_C);
        pending_d = fifo_re;
        if (fifo_re) issued_d = issued_q + ONE_C;
        // Read data lands one cycle after its pop.
        if (pending_q) begin
          for (int i = 0; i < ROW_LEN; i++) begin
            if (captured_q == CW'(i))
              row_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_r_data;
          end
          captured_d = captured_q + ONE_C;
          if (captured_q == LAST_C) state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (row_ready) begin
          rows_done_d = rows_done_q + ROWS_W'(1);
          issued_d    = '0;
          captured_d  = '0;
          state_d     = last_row ? ST_FINISH : ST_FILL;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign row_data = row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      captured_q  <= '0;
      rows_done_q <= '0;
      num_rows_q  <= '0;
      pending_q   <= 1'b0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      captured_q  <= captured_d;
      rows_done_q <= rows_done_d;
      num_rows_q  <= num_rows_d;
      pending_q   <= pending_d;
      row_q       <= row_d;
    end
  end

endmodule

// File: tb/tb_fifo_row_loader.sv
// Bench for fifo_row_loader with a behavioural FIFO upstream
// and a byte-queue scoreboard for expected rows.
module tb_fifo_row_loader;
  import fifo_row_loader_pkg::*;

  localparam int DW = 8;
  localparam int RL = 4;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [RW-1:0] num_rows;
  logic busy, done;
  logic fifo_empty, fifo_re;
  logic [DW-1:0] fifo_r_data;
  logic row_valid, row_ready;
  logic [RL*DW-1:0] row_data;

  logic push_en;
  logic [DW-1:0] push_data;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_row_loader #(
    .DATA_WIDTH(DW), .ROW_LEN(RL), .ROWS_W(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .start(start), .num_rows(num_rows),
    .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_r_data(fifo_r_data),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data)
  );

  // Upstream FIFO: registered read data, shared reset.
  logic [DW-1:0] fq[$];
  int fifo_cnt = 0;
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_r_data <= '0;
    end else begin
      if (fifo_re && fq.size() > 0)
        fifo_r_data <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
    end
    fifo_cnt <= fq.size();
  end

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every byte pushed, in order.
  logic [DW-1:0] exp_bytes[$];
  logic [RL*DW-1:0] hs_log[$];
  int hs_cnt = 0, done_cnt = 0, re_cnt = 0, busy_cnt = 0;
  int re_empty_viol = 0, stab_viol = 0;
  int last_hs_cyc = 0, done_cyc = 0;
  logic prev_valid = 1'b0, prev_hs = 1'b0;
  logic [RL*DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_valid && !prev_hs)
        if (!row_valid || row_data !== prev_data) stab_viol++;
      if (fifo_re) re_cnt++;
      if (fifo_re && fifo_empty) re_empty_viol++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (row_valid && row_ready) begin
        logic [RL*DW-1:0] e;
        hs_cnt++;
        last_hs_cyc = cyc;
        hs_log.push_back(row_data);
        if (exp_bytes.size() >= RL) begin
          e = '0;
          for (int i = 0; i < RL; i++)
            e[i*DW +: DW] = exp_bytes.pop_front();
          chk("row", row_data, e);
        end else begin
          chk("row_without_data", 1, 0);
        end
      end
      prev_valid = row_valid;
      prev_hs = row_valid && row_ready;
      prev_data = row_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    push_en = 1'b1;
    push_data = b;
    exp_bytes.push_back(b);
    tick();
    push_en = 1'b0;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    num_rows = RW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < lim && done_cnt == d0; i++) tick();
    chk(tag, done_cnt - d0, 1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_bytes.delete();
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_re"}, fifo_re, 0);
    chk({tag, "_valid"}, row_valid, 0);
    chk({tag, "_data"}, row_data, 0);
  endtask

  initial begin
    int h0, r0, d0, b0, occ;
    logic [RL*DW-1:0] held;
    rst = 1'b1;
    start = 1'b0;
    num_rows = '0;
    row_ready = 1'b0;
    push_en = 1'b0;
    push_data = '0;
    tick();
    tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();

    // Two rows back to back from a full FIFO.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    hs_log.delete();
    r0 = re_cnt;
    d0 = done_cnt;
    row_ready = 1'b1;
    go(2);
    wait_done("t1_done", 40);
    chk("t1_row0", hs_log.size() > 0 ? hs_log[0] : '1,
        32'h04030201);
    chk("t1_row1", hs_log.size() > 1 ? hs_log[1] : '1,
        32'h08070605);
    chk("t1_re_cycles", re_cnt - r0, 8);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_done_lat", done_cyc - last_hs_cyc, 1);

    // FIFO bubble mid-row.
    hs_log.delete();
    re_empty_viol = 0;
    push(8'hAA);
    push(8'hBB);
    go(1);
    for (int i = 0; i < 5; i++) tick();
    push(8'hCC);
    push(8'hDD);
    wait_done("t2_done", 40);
    chk("t2_row", hs_log.size() > 0 ? hs_log[0] : '1,
        32'hDDCCBBAA);
    chk("t2_re_empty", re_empty_viol, 0);

    // Backpressure in PRESENT.
    row_ready = 1'b0;
    stab_viol = 0;
    for (int i = 0; i < 6; i++) push(DW'(8'h40 + i));
    go(1);
    for (int i = 0; i < 20 && !row_valid; i++) tick();
    chk("t3_valid", row_valid, 1);
    held = row_data;
    occ = fifo_cnt;
    r0 = re_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("t3_valid_hold", row_valid, 1);
    chk("t3_data_hold", row_data, held);
    chk("t3_row", held, 32'h43424140);
    chk("t3_no_re", re_cnt - r0, 0);
    chk("t3_occ", fifo_cnt, occ);
    chk("t3_occ2", fifo_cnt, 2);
    chk("t3_stable", stab_viol, 0);
    row_ready = 1'b1;
    wait_done("t3_done", 10);
    do_reset();
    chk_reset_outs("t3_rst");

    // Zero rows, then start while busy.
    r0 = re_cnt;
    b0 = busy_cnt;
    go(0);
    wait_done("t4_done", 10);
    chk("t4_busy_cycles", busy_cnt - b0, 1);
    chk("t4_no_re", re_cnt - r0, 0);
    h0 = hs_cnt;
    go(1);
    go(3);
    num_rows = 8'd7;
    for (int i = 0; i < 4; i++) push(DW'(8'h50 + i));
    wait_done("t4b_done", 40);
    chk("t4b_rows", hs_cnt - h0, 1);
    chk("t4b_idle", busy, 0);

    // Reset after two of four pops.
    for (int i = 0; i < 4; i++) push(DW'(8'h21 + i));
    go(1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_outs("t5_rst");
    rst = 1'b0;
    exp_bytes.delete();
    hs_log.delete();
    tick();
    for (int i = 0; i < 4; i++) push(DW'(8'h11 + i));
    go(1);
    wait_done("t5_done", 40);
    chk("t5_row", hs_log.size() > 0 ? hs_log[0] : '1,
        32'h14131211);

    // Random push timing and backpressure, 50 rows.
    begin
      int pushed, lim;
      pushed = 0;
      h0 = hs_cnt;
      d0 = done_cnt;
      re_empty_viol = 0;
      stab_viol = 0;
      go(50);
      lim = 0;
      while (done_cnt == d0 && lim < 6000) begin
        if (pushed < 50 * RL && $urandom_range(0, 1) == 1) begin
          push_en = 1'b1;
          push_data = DW'($urandom);
          exp_bytes.push_back(push_data);
          pushed++;
        end else begin
          push_en = 1'b0;
        end
        row_ready = ($urandom_range(0, 2) != 0);
        tick();
        lim++;
      end
      push_en = 1'b0;
      row_ready = 1'b0;
      chk("t6_done", done_cnt - d0, 1);
      tick();
      tick();
      chk("t6_rows", hs_cnt - h0, 50);
      chk("t6_leftover", exp_bytes.size(), 0);
      chk("t6_re_empty", re_empty_viol, 0);
      chk("t6_stable", stab_viol, 0);
      chk("t6_done_once", done_cnt - d0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
